// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, stall hold and redirect buffering.
// Define IF_EXC_REDIRECT_EN to let exc_req redirect to EXC_VECTOR.
module if_fetch_ctrl #(
    parameter logic [29:0] START_ADDR = 30'h0000BFF,
    parameter logic [29:0] EXC_VECTOR = 30'h0000020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [29:0] br_target,
    input  logic        exc_req,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    output logic [29:0] npc,
    output logic        pc_write,
    output logic        if_valid,
    output logic        redirect_pending
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state, state_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [29:0] pend_target, pend_target_nxt;
    logic        eff_valid;
    logic [29:0] eff_target;
    logic        apply;

`ifdef IF_EXC_REDIRECT_EN
    logic pend_exc, pend_exc_nxt, eff_exc;

    // A pending exception is sticky; a fresh exception beats a pending branch,
    // and a pending branch beats a fresh one.
    always_comb begin
        eff_valid  = 1'b0;
        eff_exc    = 1'b0;
        eff_target = '0;
        if (pend_valid && pend_exc) begin
            eff_valid  = 1'b1;
            eff_exc    = 1'b1;
            eff_target = pend_target;
        end else if (exc_req) begin
            eff_valid  = 1'b1;
            eff_exc    = 1'b1;
            eff_target = EXC_VECTOR;
        end else if (pend_valid) begin
            eff_valid  = 1'b1;
            eff_target = pend_target;
        end else if (br_taken) begin
            eff_valid  = 1'b1;
            eff_target = br_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_exc <= 1'b0;
        else        pend_exc <= pend_exc_nxt;
    end

    assign pend_exc_nxt = apply ? 1'b0 : eff_exc;
`else
    logic unused_exc;
    assign unused_exc = exc_req ^ (|EXC_VECTOR);

    always_comb begin
        eff_valid  = 1'b0;
        eff_target = '0;
        if (pend_valid) begin
            eff_valid  = 1'b1;
            eff_target = pend_target;
        end else if (br_taken) begin
            eff_valid  = 1'b1;
            eff_target = br_target;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        pc_write  = 1'b0;
        if_valid  = 1'b0;
        apply     = 1'b0;
        npc       = pc + 30'd1;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (eff_valid) begin
                        apply = 1'b1;
                    end else if (stall) begin
                        state_nxt = HOLD;
                    end else begin
                        pc_write = 1'b1;
                        if_valid = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (eff_valid) begin
                    apply = 1'b1;
                end else if (!stall) begin
                    pc_write  = 1'b1;
                    if_valid  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
        if (apply) begin
            pc_write  = 1'b1;
            npc       = eff_target;
            state_nxt = FETCH;
        end
        // npc shows the boot address for as long as reset is held
        if (!reset) npc = START_ADDR;
    end

    assign pend_valid_nxt  = apply ? 1'b0 : eff_valid;
    assign pend_target_nxt = apply ? '0 : eff_target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    assign imem_req         = (state == FETCH);
    assign imem_addr        = pc;
    assign redirect_pending = pend_valid;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl; expectations follow IF_EXC_REDIRECT_EN when defined.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] pc;
    logic        stall;
    logic        br_taken;
    logic [29:0] br_target;
    logic        exc_req;
    logic        imem_ack;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic [29:0] npc;
    logic        pc_write;
    logic        if_valid;
    logic        redirect_pending;

    int checks   = 0;
    int failures = 0;

`ifdef IF_EXC_REDIRECT_EN
    localparam logic [29:0] EXC_MIX_TARGET = 30'h0000020;
`else
    localparam logic [29:0] EXC_MIX_TARGET = 30'h0000100;
`endif

    if_fetch_ctrl #(
        .START_ADDR(30'h0000BFF),
        .EXC_VECTOR(30'h0000020)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .exc_req(exc_req),
        .imem_ack(imem_ack),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .npc(npc),
        .pc_write(pc_write),
        .if_valid(if_valid),
        .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; pc = 30'h0000BFF; stall = 1'b0; br_taken = 1'b0;
        br_target = '0; exc_req = 1'b0; imem_ack = 1'b0;
        tick(); tick();
        sample();
        chk("rst_req",  imem_req, 0);
        chk("rst_pcw",  pc_write, 0);
        chk("rst_vld",  if_valid, 0);
        chk("rst_pend", redirect_pending, 0);
        chk("rst_npc",  npc, 32'h0000BFF);

        // BOOT cycle: ack ignored
        tick(); reset = 1'b1; imem_ack = 1'b1;
        sample();
        chk("boot_req", imem_req, 0);
        chk("boot_pcw", pc_write, 0);
        chk("boot_npc", npc, 32'h0000C00);

        tick(); sample();
        chk("f1_req",  imem_req, 1);
        chk("f1_addr", imem_addr, 32'h0000BFF);
        chk("f1_npc",  npc, 32'h0000C00);
        chk("f1_pcw",  pc_write, 1);
        chk("f1_vld",  if_valid, 1);

        // ack under stall, then two more stalled HOLD cycles
        tick(); pc = 30'h0000C00; stall = 1'b1;
        sample();
        chk("st1_pcw", pc_write, 0);
        chk("st1_vld", if_valid, 0);
        tick(); imem_ack = 1'b0;
        sample();
        chk("st2_req", imem_req, 0);
        chk("st2_pcw", pc_write, 0);
        chk("st2_npc", npc, 32'h0000C01);
        tick(); sample();
        chk("st3_pcw", pc_write, 0);
        tick(); stall = 1'b0;
        sample();
        chk("hold_rel_vld", if_valid, 1);
        chk("hold_rel_pcw", pc_write, 1);
        chk("hold_rel_npc", npc, 32'h0000C01);

        // branch latched while no ack
        tick(); pc = 30'h0000C01; br_taken = 1'b1; br_target = 30'h0000100;
        sample();
        chk("br_lat_pcw",  pc_write, 0);
        chk("br_lat_pend", redirect_pending, 0);
        tick(); br_taken = 1'b0;
        sample();
        chk("br_pend", redirect_pending, 1);
        chk("br_pend_pcw", pc_write, 0);
        tick(); imem_ack = 1'b1;
        sample();
        chk("br_app_npc", npc, 32'h0000100);
        chk("br_app_pcw", pc_write, 1);
        chk("br_app_vld", if_valid, 0);
        tick(); pc = 30'h0000100; imem_ack = 1'b0;
        sample();
        chk("br_clr_pend", redirect_pending, 0);
        chk("br_clr_addr", imem_addr, 32'h0000100);

        // branch pending, then exception before the ack
        tick(); br_taken = 1'b1; br_target = 30'h0000100;
        tick(); br_taken = 1'b0; exc_req = 1'b1;
        tick(); exc_req = 1'b0; imem_ack = 1'b1;
        sample();
        chk("mix_npc", npc, {2'b00, EXC_MIX_TARGET});
        chk("mix_vld", if_valid, 0);
        tick(); pc = EXC_MIX_TARGET; imem_ack = 1'b0;
        sample();
        chk("mix_pend", redirect_pending, 0);

        // redirect coincident with ack applies at once
        tick(); br_taken = 1'b1; br_target = 30'h0000200; imem_ack = 1'b1;
        sample();
        chk("same_npc", npc, 32'h0000200);
        chk("same_pcw", pc_write, 1);
        chk("same_vld", if_valid, 0);
        tick(); pc = 30'h0000200; br_taken = 1'b0; imem_ack = 1'b0;
        sample();
        chk("same_pend", redirect_pending, 0);

        // a later branch does not replace a pending one
        tick(); br_taken = 1'b1; br_target = 30'h0000300;
        tick(); br_target = 30'h0000400;
        tick(); br_taken = 1'b0; imem_ack = 1'b1;
        sample();
        chk("keep_npc", npc, 32'h0000300);

        // redirect arriving in HOLD applies despite stall
        tick(); pc = 30'h0000300; stall = 1'b1;
        tick(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 30'h0000444;
        sample();
        chk("hold_br_npc", npc, 32'h0000444);
        chk("hold_br_pcw", pc_write, 1);
        chk("hold_br_vld", if_valid, 0);
        tick(); pc = 30'h0000444; br_taken = 1'b0; stall = 1'b0;
        sample();
        chk("hold_br_req", imem_req, 1);

        // sequential wrap at top of address space
        pc = 30'h3FFFFFFF; imem_ack = 1'b1;
        sample();
        chk("wrap_npc", npc, 32'h0000000);
        chk("wrap_pcw", pc_write, 1);

        // reset during an outstanding fetch with a pending redirect
        tick(); pc = 30'h0000500; imem_ack = 1'b0; br_taken = 1'b1; br_target = 30'h0000600;
        tick(); br_taken = 1'b0;
        sample();
        chk("pre_rst_pend", redirect_pending, 1);
        tick(); reset = 1'b0;
        sample();
        chk("mid_rst_req",  imem_req, 0);
        chk("mid_rst_pcw",  pc_write, 0);
        chk("mid_rst_vld",  if_valid, 0);
        chk("mid_rst_pend", redirect_pending, 0);
        chk("mid_rst_npc",  npc, 32'h0000BFF);
        tick(); reset = 1'b1; imem_ack = 1'b1;
        sample();
        chk("re_boot_req", imem_req, 0);
        chk("re_boot_pcw", pc_write, 0);
        tick(); sample();
        chk("re_f_addr", imem_addr, 32'h0000500);
        chk("re_f_npc",  npc, 32'h0000501);
        chk("re_f_vld",  if_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter START_ADDR, default 30'h0000BFF, word address driven after reset.
REQ-002 Parameter EXC_VECTOR, default 30'h0000020, word address of the exception handler.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc  input  30 [31:2]  current PC register value.
REQ-006 stall  input  1  hazard unit holds IF this cycle.
REQ-007 br_taken  input  1  EX-stage branch/jump redirect, one-cycle pulse.
REQ-008 br_target  input  30 [31:2]  redirect target, valid with br_taken.
REQ-009 exc_req  input  1  exception redirect pulse.
REQ-010 imem_ack  input  1  instruction memory returns data for the outstanding request.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  30 [31:2]  fetch word address.
REQ-013 npc  output  30 [31:2]  next PC to the PC register.
REQ-014 pc_write  output  1  PC register load enable.
REQ-015 if_valid  output  1  fetched instruction is valid for IF/ID.
REQ-016 redirect_pending  output  1  a redirect is latched and not yet applied.

Function
REQ-017 FSM states SHALL be BOOT, FETCH, HOLD; BOOT lasts exactly one cycle after reset release, then FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc combinationally; in BOOT and HOLD, imem_req SHALL be 0.
REQ-019 On imem_ack in FETCH with stall=0 and no pending redirect: pc_write=1, npc=pc+1 (30-bit wrap, 30'h3FFFFFFF -> 0), if_valid=1, remain in FETCH.
REQ-020 On imem_ack in FETCH with stall=1: pc_write=0, if_valid=0, go to HOLD, instruction retained as held.
REQ-021 In HOLD, the first cycle with stall=0 SHALL assert if_valid=1, pc_write=1, npc=pc+1, and return to FETCH.
REQ-022 Redirect priority SHALL be exc_req > br_taken > sequential; redirect target is EXC_VECTOR or br_target.
REQ-023 A redirect arriving in any state SHALL be latched into the pending register (target + source) and set redirect_pending=1 on the next cycle.
REQ-024 A pending exception SHALL be overwritten only by nothing; a pending branch SHALL be overwritten by a new exception; a new branch SHALL NOT replace an existing pending entry.
REQ-025 Redirect application: on imem_ack in FETCH, or any cycle in HOLD, while pending (or redirect arriving this cycle): pc_write=1, npc=target, if_valid=0 (fetched/held instruction squashed), pending cleared, state FETCH; applied regardless of stall.
REQ-026 Redirect and imem_ack in the same cycle SHALL apply the incoming redirect immediately, without a latching cycle.
REQ-027 pc_write SHALL be 0 in every cycle not covered by REQ-019, REQ-021, REQ-025.
REQ-028 npc SHALL equal pc+1 whenever pc_write=0 (defined value, no X).

Reset
REQ-029 While reset=0: state=BOOT, pending cleared, imem_req=0, pc_write=0, if_valid=0, redirect_pending=0, npc=START_ADDR.
REQ-030 Reset asserted mid-fetch SHALL abandon the outstanding request; an imem_ack in the BOOT cycle SHALL be ignored.

Configuration
REQ-031 Macro IF_EXC_REDIRECT_EN defined: exc_req handled per REQ-022..REQ-026.
REQ-032 Macro IF_EXC_REDIRECT_EN undefined: exc_req port present but ignored, EXC_VECTOR unused, pending register holds branch targets only.

Verification
REQ-033 Release reset, pc=30'h0000BFF, imem_ack each FETCH cycle -> one BOOT cycle with imem_req=0, then npc=30'h0000C00, pc_write=1, if_valid=1.
REQ-034 imem_ack with stall=1 for 3 cycles -> HOLD, pc_write=0 for 3 cycles, then if_valid=1, pc_write=1 on the cycle stall drops.
REQ-035 br_taken, br_target=30'h0000100 while imem_ack=0 -> redirect_pending=1; next imem_ack -> npc=30'h0000100, if_valid=0, redirect_pending=0.
REQ-036 br_taken (30'h0000100) then exc_req before ack -> npc=30'h0000020 on ack; with macro undefined -> npc=30'h0000100.
REQ-037 pc=30'h3FFFFFFF, imem_ack, stall=0 -> npc=30'h0000000, pc_write=1.
REQ-038 reset pulsed low during outstanding fetch with pending redirect -> all outputs at reset values, redirect_pending=0, first fetch after BOOT at pc.
